// File: rtl/rj_load_sequencer.sv
// rj coefficient memory controller: sequences LOAD-phase writes and SCAN-phase reads.
// Optional RJ_CHECKSUM_EN adds an XOR checksum of every accepted rj word.
module rj_load_sequencer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              Sclk,
  input  logic              Reset,
  input  logic              start_load,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_in,
  input  logic              scan_start,
  input  logic              scan_next,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              load_done,
  output logic              scan_last,
`ifdef RJ_CHECKSUM_EN
  output logic [DATA_W-1:0] rj_checksum,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, READY, SCAN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wcnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_re;
  logic [ADDR_W-1:0]   r_raddr;
  logic                r_load_done;
  logic                r_scan_last;
  logic                r_busy;
  logic [ADDR_W-1:0]   w_raddr_inc;

  assign w_raddr_inc = r_raddr + ADDR_W'(1);

  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_wcnt      <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_re        <= 1'b0;
      r_raddr     <= '0;
      r_load_done <= 1'b0;
      r_scan_last <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_load) begin
            r_state <= LOAD;
            r_wcnt  <= '0;
            r_busy  <= 1'b1;
          end
        end
        LOAD: begin
          // A restart drops any word presented in the same cycle.
          if (start_load) begin
            r_wcnt      <= '0;
            r_load_done <= 1'b0;
          end else if (word_valid) begin
            r_we    <= 1'b1;
            r_waddr <= r_wcnt;
            r_wdata <= word_in;
            if (r_wcnt == LAST) begin
              r_wcnt      <= '0;
              r_state     <= READY;
              r_load_done <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_wcnt <= r_wcnt + ADDR_W'(1);
            end
          end
        end
        READY: begin
          if (start_load) begin
            r_state     <= LOAD;
            r_wcnt      <= '0;
            r_load_done <= 1'b0;
            r_busy      <= 1'b1;
          end else if (scan_start) begin
            r_state     <= SCAN;
            r_re        <= 1'b1;
            r_raddr     <= '0;
            r_scan_last <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        SCAN: begin
          if (start_load) begin
            r_state     <= LOAD;
            r_wcnt      <= '0;
            r_load_done <= 1'b0;
            r_re        <= 1'b0;
            r_raddr     <= '0;
            r_scan_last <= 1'b0;
          end else if (scan_start) begin
            r_raddr     <= '0;
            r_scan_last <= 1'b0;
          end else if (scan_next) begin
            if (r_scan_last) begin
              r_state     <= READY;
              r_re        <= 1'b0;
              r_raddr     <= '0;
              r_scan_last <= 1'b0;
              r_busy      <= 1'b0;
            end else begin
              r_raddr     <= w_raddr_inc;
              r_scan_last <= (w_raddr_inc == LAST);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RJ_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // start_load always lands in LOAD, so clearing on it matches every state.
  always_ff @(posedge Sclk or posedge Reset) begin
    if (Reset) begin
      r_checksum <= '0;
    end else if (start_load) begin
      r_checksum <= '0;
    end else if (r_state == LOAD && word_valid) begin
      r_checksum <= r_checksum ^ word_in;
    end
  end

  assign rj_checksum = r_checksum;
`endif

  assign mem_we    = r_we;
  assign mem_waddr = r_waddr;
  assign mem_wdata = r_wdata;
  assign mem_re    = r_re;
  assign mem_raddr = r_raddr;
  assign load_done = r_load_done;
  assign scan_last = r_scan_last;
  assign busy      = r_busy;

endmodule
